dmem_copy_engine: RTL and testbench
===================================

// Module: dmem_copy_engine
// PURPOSE
//  Initiator for the data-memory bank port (memread/memwrite/address/writedata/readdata).
//  Copies a block of LEN 16-bit words from src to dst, with start/busy/done control.
//  Sits beside the single-cycle datapath and shares the memory port through an external mux gated by busy.
// PARAMETERS
//  ADDR_W  16  byte-address width; word index = addr[ADDR_W-1:1]
//  DATA_W  16  memory word width
//  LEN_W   8   width of word-count input (max 255 words per transfer)
// PORTS
//  clk        in   1       rising-edge clock
//  rst_n      in   1       asynchronous, active-low reset
//  start      in   1       1-cycle request; sampled only in IDLE
//  src_addr   in   ADDR_W  source byte address; bit0 ignored
//  dst_addr   in   ADDR_W  destination byte address; bit0 ignored
//  len        in   LEN_W   words to transfer
//  busy       out  1       high from cycle after accepted start until done cycle inclusive
//  done       out  1       1-cycle pulse at transfer completion
//  mem_read   out  1       to bank memread
//  mem_write  out  1       to bank memwrite (bank writes on posedge clk)
//  mem_addr   out  ADDR_W  to bank address; bit0 always 0
//  mem_wdata  out  DATA_W  to bank writedata
//  mem_rdata  in   DATA_W  from bank readdata (combinational, valid same cycle as mem_read)
//  fill_mode  in   1       [DMEM_COPY_FILL_EN only] 1 = fill dst with fill_value, no reads
//  fill_value in   DATA_W  [DMEM_COPY_FILL_EN only] pattern written in fill mode
// BEHAVIOUR
//  Reset: state=IDLE; busy, done, mem_read, mem_write = 0; mem_addr, mem_wdata = 0; internal regs cleared.
//  Reset mid-transfer aborts immediately; partially written words stay; no done pulse.
//  FSM: IDLE -> RD -> WR -> (RD | FIN) ; FIN -> IDLE.
//   IDLE: start=1 latches src&~1, dst&~1, len into cnt. cnt=0 -> FIN (no memory access), else -> RD.
//   RD: mem_read=1, mem_addr=src_ptr; data register captures mem_rdata at cycle end; src_ptr += 2.
//   WR: mem_write=1, mem_addr=dst_ptr, mem_wdata=data reg; dst_ptr += 2; cnt -= 1;
//       cnt becomes 0 -> FIN, else -> RD.
//   FIN: done=1, busy=1, strobes 0; -> IDLE.
//  Latency: 2 cycles/word copy; total = 2*len + 1 cycles from start to done (FIN cycle); len=0 -> 1.
//  mem_read and mem_write never both high; outside RD/WR both 0, mem_addr/mem_wdata hold last value.
//  start while busy: ignored, no queuing. start in FIN cycle: ignored.
//  Pointer arithmetic modulo 2^ADDR_W: 16'hFFFE + 2 wraps to 16'h0000.
//  Overlap: strictly ascending word-by-word copy; dst within (src, src+2*len) replicates earlier words (defined, not an error).
//  Inputs src_addr/dst_addr/len may change while busy without effect.
// CONFIGURATION
//  DMEM_COPY_FILL_EN defined: fill_mode/fill_value ports exist, latched at start. fill_mode=1 skips RD:
//   IDLE -> WR repeated, 1 cycle/word, mem_wdata=latched fill_value; done at len+1 cycles; mem_read stays 0.
//  Not defined: ports absent; engine is copy-only, behaviour exactly as above.
// STRUCTURE
//  Shared package/include dmem_copy_pkg: FSM state encodings (IDLE, RD, WR, FIN), ADDR_W/DATA_W/LEN_W defaults,
//   word step constant ADDR_STEP = 2.
//  One sub-module: dmem_addr_step (registered byte pointer, load/increment by ADDR_STEP, wrap, bit0 forced 0),
//   instantiated twice (src, dst).
// TESTING (bench instantiates DMemBank with this engine on its port)
//  1. Preload mem[0x10..0x16]=1,2,3,4; start src=0x10 dst=0x40 len=4 -> mem[0x40..0x46]=1,2,3,4; done at cycle 9; busy 9 cycles.
//  2. len=0 src=0x10 dst=0x20 -> done 1 cycle after start; mem_read/mem_write never asserted; memory unchanged.
//  3. src=0xFFFC dst=0x0100 len=3, mem[0xFFFC]=A,mem[0xFFFE]=B,mem[0]=C -> mem[0x100..0x104]=A,B,C (wrap on read side).
//  4. Second start pulsed at cycle 3 of a len=4 copy with different addresses -> ignored; single done; only first copy performed.
//  5. rst_n low during 2nd WR of len=4 -> outputs 0 next sample, state IDLE, only word 0 (and maybe 1) written, no done.
//  6. [DMEM_COPY_FILL_EN] fill_mode=1 fill_value=16'hBEEF dst=0x80 len=5 -> mem[0x80..0x88]=BEEF; done at cycle 6; mem_read never high.

Source files
------------

// File: rtl/dmem_copy_pkg.sv
// Shared definitions for the data-memory copy engine: default widths, word step and FSM states.
package dmem_copy_pkg;

    localparam int unsigned ADDR_W    = 16;
    localparam int unsigned DATA_W    = 16;
    localparam int unsigned LEN_W     = 8;
    localparam int unsigned ADDR_STEP = 2;

    typedef enum logic [1:0] {
        StIdle,
        StRd,
        StWr,
        StFin
    } state_e;

endpackage

// File: rtl/dmem_addr_step.sv
// Registered byte pointer: loads a word-aligned address, then advances one word per increment.
module dmem_addr_step #(
    parameter int unsigned ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              inc,
    input  logic [ADDR_W-1:0] load_addr,
    output logic [ADDR_W-1:0] ptr
);
    import dmem_copy_pkg::*;

    logic [ADDR_W-1:0] ptr_q;

    // Wrap past the top of the address space falls out of the modulo-2^ADDR_W add.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else if (load) begin
            ptr_q <= load_addr & ~ADDR_W'(1);
        end else if (inc) begin
            ptr_q <= ptr_q + ADDR_W'(ADDR_STEP);
        end
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/dmem_copy_engine.sv
// Block copy engine on the data-memory port; optional fill mode enabled by DMEM_COPY_FILL_EN.
module dmem_copy_engine #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned LEN_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [LEN_W-1:0]  len,
    output logic              busy,
    output logic              done,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
`ifdef DMEM_COPY_FILL_EN
    input  logic              fill_mode,
    input  logic [DATA_W-1:0] fill_value,
`endif
    input  logic [DATA_W-1:0] mem_rdata
);
    import dmem_copy_pkg::*;

    state_e            state_q, state_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] data_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [ADDR_W-1:0] src_ptr, dst_ptr;
    logic              accept;
    logic              fill_start;
    logic              fill_q;
    logic [DATA_W-1:0] fill_val_q;

    assign accept = (state_q == StIdle) && start;

`ifdef DMEM_COPY_FILL_EN
    assign fill_start = fill_mode;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill_q     <= 1'b0;
            fill_val_q <= '0;
        end else if (accept) begin
            fill_q     <= fill_mode;
            fill_val_q <= fill_value;
        end
    end
`else
    assign fill_start = 1'b0;
    assign fill_q     = 1'b0;
    assign fill_val_q = '0;
`endif

    dmem_addr_step #(
        .ADDR_W(ADDR_W)
    ) u_src_step (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (accept),
        .inc      (state_q == StRd),
        .load_addr(src_addr),
        .ptr      (src_ptr)
    );

    dmem_addr_step #(
        .ADDR_W(ADDR_W)
    ) u_dst_step (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (accept),
        .inc      (state_q == StWr),
        .load_addr(dst_addr),
        .ptr      (dst_ptr)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        busy      = 1'b0;
        done      = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    cnt_d = len;
                    if (len == '0) begin
                        state_d = StFin;
                    end else if (fill_start) begin
                        state_d = StWr;
                    end else begin
                        state_d = StRd;
                    end
                end
            end
            StRd: begin
                busy     = 1'b1;
                mem_read = 1'b1;
                mem_addr = src_ptr;
                state_d  = StWr;
            end
            StWr: begin
                busy      = 1'b1;
                mem_write = 1'b1;
                mem_addr  = dst_ptr;
                mem_wdata = fill_q ? fill_val_q : data_q;
                cnt_d     = cnt_q - LEN_W'(1);
                if (cnt_q == LEN_W'(1)) begin
                    state_d = StFin;
                end else if (fill_q) begin
                    state_d = StWr;
                end else begin
                    state_d = StRd;
                end
            end
            StFin: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // addr_q/wdata_q keep the port stable between accesses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            data_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (state_q == StRd) begin
                data_q <= mem_rdata;
            end
            if (mem_read || mem_write) begin
                addr_q <= mem_addr;
            end
            if (mem_write) begin
                wdata_q <= mem_wdata;
            end
        end
    end

endmodule

// File: tb/tb_dmem_copy_engine.sv
// Self-checking bench: table-driven and random copies against an array-based memory model.
module tb_dmem_copy_engine;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] src_addr = '0;
    logic [15:0] dst_addr = '0;
    logic [7:0]  len = '0;
    logic        busy, done, mem_read, mem_write;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic        fill_mode = 1'b0;
    logic [15:0] fill_value = '0;

    logic [15:0] mem   [0:32767];
    logic [15:0] model [0:32767];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    dmem_copy_engine dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .src_addr  (src_addr),
        .dst_addr  (dst_addr),
        .len       (len),
        .busy      (busy),
        .done      (done),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
`ifdef DMEM_COPY_FILL_EN
        .fill_mode (fill_mode),
        .fill_value(fill_value),
`endif
        .mem_rdata (mem_rdata)
    );

    // Bank stand-in: combinational read, write on rising edge.
    assign mem_rdata = mem[mem_addr[15:1]];
    always @(posedge clk) begin
        if (mem_write) mem[mem_addr[15:1]] <= mem_wdata;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && busy) begin
            checks++;
            if ((mem_read && mem_write) || mem_addr[0]) begin
                errors++;
                $display("FAIL port_rules: rd=%0b wr=%0b addr=%0h required exclusive strobes, even addr",
                         mem_read, mem_write, mem_addr);
            end
        end
    end

    task automatic cmp_mem(input string name);
        int nmis = 0;
        int first = -1;
        for (int i = 0; i < 32768; i++) begin
            if (mem[i] !== model[i]) begin
                nmis++;
                if (first < 0) first = i;
            end
        end
        if (nmis != 0) $display("first differing byte addr %0h", first * 2);
        chk({"mem_", name}, nmis, 0);
    endtask

    // Reference: ascending word-by-word copy or fill, addresses modulo 64 KiB.
    task automatic model_xfer(input logic [15:0] s, input logic [15:0] d, input int l,
                              input logic f, input logic [15:0] fv);
        int sw = s / 2;
        int dw = d / 2;
        for (int i = 0; i < l; i++) begin
            model[(dw + i) % 32768] = f ? fv : model[(sw + i) % 32768];
        end
    endtask

    task automatic run(input string name, input logic [15:0] s, input logic [15:0] d,
                       input logic [7:0] l, input logic f, input logic [15:0] fv, input int inj);
        int exp_cyc = f ? int'(l) + 1 : 2 * int'(l) + 1;
        int cyc = 0;
        int busy_n = 0;
        int rd = 0;
        int wr = 0;
        int dones = 0;
        model = mem;
        model_xfer(s, d, int'(l), f, fv);
        @(negedge clk);
        src_addr = s; dst_addr = d; len = l; fill_mode = f; fill_value = fv; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        src_addr = 16'($urandom); dst_addr = 16'($urandom); len = 8'($urandom);
        fill_mode = 1'($urandom); fill_value = 16'($urandom);
        while (dones == 0 && cyc < 1000) begin
            @(negedge clk);
            cyc++;
            if (busy) busy_n++;
            if (mem_read) rd++;
            if (mem_write) wr++;
            if (done) dones++;
            start = (cyc == inj);
        end
        chk({name, "_done_cycle"}, cyc, exp_cyc);
        chk({name, "_busy_cycles"}, busy_n, exp_cyc);
        chk({name, "_reads"}, rd, f ? 0 : int'(l));
        chk({name, "_writes"}, wr, int'(l));
        @(negedge clk);
        start = 1'b0;
        chk({name, "_idle_after"}, {30'd0, busy, done}, 32'd0);
        cmp_mem(name);
    endtask

    typedef struct {
        string       name;
        logic [15:0] src;
        logic [15:0] dst;
        logic [7:0]  len;
        int          inj;
    } vec_t;

    vec_t vecs [7];

    initial begin
        for (int i = 0; i < 32768; i++) mem[i] = 16'($urandom);
        for (int i = 0; i < 4; i++) mem[8 + i] = 16'(i + 1);
        mem[16'h7FFE] = 16'hAAAA;
        mem[16'h7FFF] = 16'hBBBB;
        mem[0]        = 16'hCCCC;

        #12;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_rd", mem_read, 0);
        chk("rst_wr", mem_write, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        @(negedge clk);
        rst_n = 1'b1;

        vecs[0] = '{"basic", 16'h0010, 16'h0040, 8'd4, 0};
        vecs[1] = '{"len0", 16'h0010, 16'h0020, 8'd0, 0};
        vecs[2] = '{"src_wrap", 16'hFFFC, 16'h0100, 8'd3, 0};
        vecs[3] = '{"start_busy", 16'h0010, 16'h0600, 8'd4, 3};
        vecs[4] = '{"start_fin", 16'h0700, 16'h0800, 8'd3, 7};
        vecs[5] = '{"overlap", 16'h0200, 16'h0202, 8'd5, 0};
        vecs[6] = '{"odd_dstwrap", 16'h0301, 16'hFFFF, 8'd3, 0};
        for (int i = 0; i < 7; i++) begin
            run(vecs[i].name, vecs[i].src, vecs[i].dst, vecs[i].len, 1'b0, 16'h0, vecs[i].inj);
            if (i == 0) begin
                for (int k = 0; k < 4; k++) chk("basic_word", mem[16'h20 + k], 32'(k + 1));
            end
            if (i == 2) begin
                chk("wrap_a", mem[16'h80], 16'hAAAA);
                chk("wrap_b", mem[16'h81], 16'hBBBB);
                chk("wrap_c", mem[16'h82], 16'hCCCC);
            end
        end

`ifdef DMEM_COPY_FILL_EN
        run("fill", 16'h1234, 16'h0080, 8'd5, 1'b1, 16'hBEEF, 0);
        for (int k = 0; k < 5; k++) chk("fill_word", mem[16'h40 + k], 16'hBEEF);
`endif

        // Reset during the second write of a 4-word copy.
        begin
            int dones = 0;
            model = mem;
            model[16'h0900 / 2] = model[16'h0010 / 2];
            @(negedge clk);
            src_addr = 16'h0010; dst_addr = 16'h0900; len = 8'd4; fill_mode = 1'b0; start = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
            for (int c = 1; c <= 4; c++) begin
                @(negedge clk);
                if (done) dones++;
            end
            chk("abort_in_wr", mem_write, 1);
            rst_n = 1'b0;
            #1;
            chk("abort_outputs", {busy, done, mem_read, mem_write}, 0);
            chk("abort_addr", mem_addr, 0);
            chk("abort_wdata", mem_wdata, 0);
            @(negedge clk);
            rst_n = 1'b1;
            for (int c = 0; c < 10; c++) begin
                @(negedge clk);
                if (done || busy) dones++;
            end
            chk("abort_no_done", dones, 0);
            cmp_mem("abort");
        end

        for (int r = 0; r < 20; r++) begin
            logic f;
            f = 1'b0;
`ifdef DMEM_COPY_FILL_EN
            f = 1'($urandom_range(0, 1));
`endif
            run("rand", 16'($urandom), 16'($urandom), 8'($urandom_range(0, 40)), f,
                16'($urandom), 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
